// File: rtl/fifo_drain.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fifo_drain
//
// Purpose
//   Drains one frame from an external FIFO whose read side is clocked by a
//   strobe that this block generates (rd_clk). The strobe is derived from the
//   single system clock clk_100M. Every word read is presented on a
//   valid/ready stream. The final word of a frame carries m_last.
//
//   A frame is started by start while the FIFO reports full. The frame ends
//   after DEPTH words, or earlier if the FIFO reports empty when a word is
//   sampled.
//
//   The stream has back-pressure. While a word waits for m_ready, no new
//   strobe edge is generated, so no FIFO word can be lost.
//
// Optional feature
//   FIFO_DRAIN_CHECKSUM_EN : when defined, one extra stream word follows the
//   last data word. It holds the modulo-2^DATA_WIDTH sum of the frame's data
//   words and takes over m_last. No strobe edge is generated for it. When the
//   macro is undefined, no checksum registers exist.
//
// Parameters
//   DATA_WIDTH : FIFO / stream word width
//   DEPTH      : words per frame (FIFO depth), >= 2
//   CLK_DIV    : clk_100M cycles per rd_clk half period, >= 2
//
// Ports
//   clk_100M   in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   start      in   drain request (honoured in IDLE only, and only with fifo_full)
//   fifo_full  in   FIFO write-side full flag
//   fifo_empty in   FIFO read-side empty flag
//   fifo_data  in   FIFO read data
//   rd_en      out  FIFO read enable, high for the whole read phase of a frame
//   rd_clk     out  generated FIFO read strobe, one word per rising edge
//   m_data     out  stream data
//   m_valid    out  stream valid
//   m_ready    in   stream ready
//   m_last     out  last word of the frame
//   busy       out  high whenever the FSM is not IDLE
//   done       out  one-cycle pulse at frame completion
// -----------------------------------------------------------------------------
module fifo_drain #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 1000,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk_100M,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  fifo_full,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  rd_en,
  output logic                  rd_clk,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  // Both counters need at least one bit, even for the smallest legal values.
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] ARM_LAST = DIV_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    STROBE_HI,
    STROBE_LO,
    OUT,
    FIN
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;            // cycle count within ARM / strobe half periods
  logic [CNT_W-1:0]        word_cnt_q, word_cnt_d;  // accepted data words in this frame
  logic                    rd_en_q, rd_en_d;
  logic                    rd_clk_q, rd_clk_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_last_q, m_last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    final_q, final_d;        // word held in OUT is the last data word
`ifdef FIFO_DRAIN_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]   csum_q, csum_d;          // running sum of sampled data words
  logic                    csum_phase_q, csum_phase_d;
`else
  // Without the checksum feature, the frame ends directly on the last data word.
`endif

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    word_cnt_d = word_cnt_q;
    rd_en_d    = rd_en_q;
    rd_clk_d   = rd_clk_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    done_d     = 1'b0;
    final_d    = final_q;
`ifdef FIFO_DRAIN_CHECKSUM_EN
    csum_d       = csum_q;
    csum_phase_d = csum_phase_q;
`endif

    case (state_q)
      IDLE: begin
        if (start && fifo_full) begin
          state_d = ARM;
          div_d   = '0;
        end
      end

      // rd_en stays low for two cycles. This gives the FIFO a clean rising
      // edge on rd_en.
      ARM: begin
        if (div_q == ARM_LAST) begin
          div_d    = '0;
          rd_en_d  = 1'b1;
          rd_clk_d = 1'b1;
          state_d  = STROBE_HI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      STROBE_HI: begin
        if (div_q == DIV_LAST) begin
          div_d    = '0;
          rd_clk_d = 1'b0;
          state_d  = STROBE_LO;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      // The FIFO output has settled for a whole half period. Its data and its
      // empty flag are sampled together on the last low cycle.
      STROBE_LO: begin
        if (div_q == DIV_LAST) begin
          div_d     = '0;
          m_data_d  = fifo_data;
          m_valid_d = 1'b1;
          final_d   = (word_cnt_q == CNT_LAST) || fifo_empty;
`ifdef FIFO_DRAIN_CHECKSUM_EN
          csum_d    = csum_q + fifo_data;
          m_last_d  = 1'b0;
`else
          m_last_d  = (word_cnt_q == CNT_LAST) || fifo_empty;
`endif
          state_d   = OUT;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      // Hold the word until the handshake completes. No strobe edge is
      // generated here, so a stalled sink simply pauses the FIFO.
      OUT: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (final_q) begin
`ifdef FIFO_DRAIN_CHECKSUM_EN
            if (csum_phase_q) begin
              state_d = FIN;
              rd_en_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              // The checksum word is loaded on the next cycle. m_valid
              // therefore drops for one cycle between the two words.
              csum_phase_d = 1'b1;
            end
`else
            state_d = FIN;
            rd_en_d = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            div_d      = '0;
            rd_clk_d   = 1'b1;
            state_d    = STROBE_HI;
          end
        end
`ifdef FIFO_DRAIN_CHECKSUM_EN
        else if (!m_valid_q && csum_phase_q) begin
          m_data_d  = csum_q;
          m_valid_d = 1'b1;
          m_last_d  = 1'b1;
        end
`endif
      end

      // done was raised on entry to FIN. It is high during this one cycle.
      FIN: begin
        state_d    = IDLE;
        word_cnt_d = '0;
        final_d    = 1'b0;
        rd_en_d    = 1'b0;
`ifdef FIFO_DRAIN_CHECKSUM_EN
        csum_d       = '0;
        csum_phase_d = 1'b0;
`endif
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      div_q      <= '0;
      word_cnt_q <= '0;
      rd_en_q    <= 1'b0;
      rd_clk_q   <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      final_q    <= 1'b0;
`ifdef FIFO_DRAIN_CHECKSUM_EN
      csum_q       <= '0;
      csum_phase_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      word_cnt_q <= word_cnt_d;
      rd_en_q    <= rd_en_d;
      rd_clk_q   <= rd_clk_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      final_q    <= final_d;
`ifdef FIFO_DRAIN_CHECKSUM_EN
      csum_q       <= csum_d;
      csum_phase_q <= csum_phase_d;
`endif
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_clk  = rd_clk_q;
  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_fifo_drain.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fifo_drain
//
// Directed-vector bench for fifo_drain with DEPTH=4 and CLK_DIV=2.
// A small FIFO model returns the words of src[] on successive rd_clk rising
// edges. A monitor records every accepted stream word and every rd_clk edge.
// Expected values are hand-computed tables, loaded per frame.
// -----------------------------------------------------------------------------
module tb_fifo_drain;

  localparam int DW      = 12;
  localparam int DEPTH   = 4;
  localparam int CLK_DIV = 2;
`ifdef FIFO_DRAIN_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk_100M = 1'b0;
  logic          rst      = 1'b1;
  logic          start    = 1'b0;
  logic          fifo_full = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          rd_en, rd_clk;
  logic [DW-1:0] m_data;
  logic          m_valid, m_last, busy, done;
  logic          m_ready = 1'b1;

  fifo_drain #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk_100M   (clk_100M),
    .rst        (rst),
    .start      (start),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .rd_en      (rd_en),
    .rd_clk     (rd_clk),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk_100M = ~clk_100M;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk_100M) cyc <= cyc + 1;

  // ---------------- FIFO model ----------------
  logic [DW-1:0] src [0:7];
  int src_base = 0;     // rd_edges value at the start of the current frame
  int empty_at = 100;   // empty after this many reads in the frame
  int rd_edges = 0;
  int edge_cyc [$];

  always @(posedge rd_clk) begin
    rd_edges = rd_edges + 1;
    edge_cyc.push_back(cyc);
  end

  always_comb begin
    int k;
    k = rd_edges - src_base;
    fifo_data = '0;
    if (k >= 1 && k <= 8) fifo_data = src[k-1];
    fifo_empty = (k >= empty_at);
  end

  // ---------------- stream / activity monitor ----------------
  logic [DW-1:0] got_d [$];
  logic          got_l [$];
  int done_cyc = 0;
  int busy_cyc = 0;
  int rden_cyc = 0;

  always @(negedge clk_100M) begin
    if (m_valid && m_ready) begin
      got_d.push_back(m_data);
      got_l.push_back(m_last);
    end
    if (done)  done_cyc++;
    if (busy)  busy_cyc++;
    if (rd_en) rden_cyc++;
  end

  // ---------------- expected frame table ----------------
  int exp_w [0:7];
  int exp_n;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100M);
    #1;
  endtask

  // Loads src with a..d and the expected stream with the first n of them.
  // If the checksum feature is enabled, sum is appended as one extra word.
  task automatic load_frame(input int a, input int b, input int c, input int d,
                            input int n, input int sum);
    src[0] = DW'(a); src[1] = DW'(b); src[2] = DW'(c); src[3] = DW'(d);
    exp_w[0] = a; exp_w[1] = b; exp_w[2] = c; exp_w[3] = d;
    exp_n = n;
    if (CSUM) begin
      exp_w[n] = sum;
      exp_n    = n + 1;
    end
  endtask

  task automatic begin_frame(output int gb, output int eb, output int db);
    gb = got_d.size();
    eb = edge_cyc.size();
    db = done_cyc;
    src_base = rd_edges;
  endtask

  task automatic pulse_start(input logic full);
    fifo_full = full;
    start     = 1'b1;
    tick(1);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      tick(1);
      n++;
    end
    check_val({tag, "_done_seen"}, {31'd0, done}, 1);
    tick(2);
  endtask

  task automatic check_frame(input string tag, input int gb, input int eb,
                             input int nedges, input bit spacing);
    check_val({tag, "_nwords"}, got_d.size() - gb, exp_n);
    for (int i = 0; i < exp_n; i++) begin
      if (gb + i < got_d.size()) begin
        check_val($sformatf("%s_data%0d", tag, i), {20'd0, got_d[gb+i]}, exp_w[i]);
        check_val($sformatf("%s_last%0d", tag, i), {31'd0, got_l[gb+i]}, (i == exp_n - 1) ? 1 : 0);
      end
    end
    check_val({tag, "_rd_clk_edges"}, edge_cyc.size() - eb, nedges);
    if (spacing) begin
      for (int i = eb + 1; i < edge_cyc.size(); i++)
        check_val($sformatf("%s_edge_gap%0d", tag, i - eb), edge_cyc[i] - edge_cyc[i-1], 5);
    end
    $display("frame %s: words=%0d rd_clk_edges=%0d", tag, got_d.size() - gb, edge_cyc.size() - eb);
  endtask

  initial begin
    int gb, eb, db, n, bad, e0, bb, rb;

    for (int i = 0; i < 8; i++) src[i] = '0;

    // ---- reset state ----
    tick(3);
    check_val("rst_ctrl", {26'd0, rd_en, rd_clk, m_valid, m_last, busy, done}, 0);
    check_val("rst_mdata", {20'd0, m_data}, 0);
    rst = 1'b0;
    tick(2);

    // ---- nominal frame 1,2,3,4 (checksum 10) ----
    load_frame(1, 2, 3, 4, 4, 10);
    begin_frame(gb, eb, db);
    pulse_start(1'b1);
    wait_done("f1", 300);
    check_frame("f1", gb, eb, 4, 1'b1);
    check_val("f1_done_width", done_cyc - db, 1);
    check_val("f1_rd_en_after", {31'd0, rd_en}, 0);
    check_val("f1_busy_after", {31'd0, busy}, 0);

    // ---- start without fifo_full is ignored ----
    begin_frame(gb, eb, db);
    bb = busy_cyc;
    rb = rden_cyc;
    pulse_start(1'b0);
    tick(20);
    check_val("nofull_busy_cycles", busy_cyc - bb, 0);
    check_val("nofull_rd_en_cycles", rden_cyc - rb, 0);
    check_val("nofull_rd_clk_edges", edge_cyc.size() - eb, 0);
    $display("frame nofull: busy_cycles=%0d rd_clk_edges=%0d", busy_cyc - bb, edge_cyc.size() - eb);

    // ---- back-pressure: stall on word 2 for 10 cycles ----
    load_frame(1, 2, 3, 4, 4, 10);
    begin_frame(gb, eb, db);
    pulse_start(1'b1);
    n = 0;
    while (got_d.size() < gb + 1 && n < 200) begin
      @(negedge clk_100M);
      n++;
    end
    check_val("stall_w1_accepted", got_d.size() - gb, 1);
    @(posedge clk_100M);
    #1;
    m_ready = 1'b0;
    n = 0;
    while (m_valid !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    check_val("stall_w2_valid", {31'd0, m_valid}, 1);
    check_val("stall_w2_data", {20'd0, m_data}, 2);
    e0  = rd_edges;
    bad = 0;
    repeat (10) begin
      if (m_data !== DW'(2) || m_valid !== 1'b1 || m_last !== 1'b0) bad++;
      tick(1);
    end
    check_val("stall_hold_unstable", bad, 0);
    check_val("stall_new_edges", rd_edges - e0, 0);
    check_val("stall_edges_so_far", rd_edges - src_base, 2);
    m_ready = 1'b1;
    wait_done("stall", 300);
    check_frame("stall", gb, eb, 4, 1'b0);

    // ---- early empty at word 3 (checksum 6) ----
    load_frame(1, 2, 3, 4, 3, 6);
    begin_frame(gb, eb, db);
    empty_at = 3;
    pulse_start(1'b1);
    wait_done("empty", 300);
    check_frame("empty", gb, eb, 3, 1'b1);
    check_val("empty_done_width", done_cyc - db, 1);
    empty_at = 100;

    // ---- reset during STROBE_HI of word 2 ----
    load_frame(1, 2, 3, 4, 4, 10);
    begin_frame(gb, eb, db);
    pulse_start(1'b1);
    n = 0;
    while (rd_edges - src_base < 2 && n < 100) begin
      @(negedge clk_100M);
      n++;
    end
    check_val("midrst_reached_w2", rd_edges - src_base, 2);
    #2;
    rst = 1'b1;
    #1;
    check_val("midrst_ctrl", {26'd0, rd_en, rd_clk, m_valid, m_last, busy, done}, 0);
    check_val("midrst_mdata", {20'd0, m_data}, 0);
    tick(3);
    rst = 1'b0;
    tick(20);
    check_val("midrst_no_done", done_cyc - db, 0);
    check_val("midrst_no_more_edges", rd_edges - src_base, 2);
    check_val("midrst_idle", {31'd0, busy}, 0);
    $display("frame midrst: rd_clk_edges=%0d done_pulses=%0d", rd_edges - src_base, done_cyc - db);

    // ---- fresh frame after reset, wrap-around data (checksum 4104 mod 4096 = 8) ----
    load_frame(4095, 2, 3, 4, 4, 8);
    begin_frame(gb, eb, db);
    pulse_start(1'b1);
    wait_done("wrap", 300);
    check_frame("wrap", gb, eb, 4, 1'b1);
    check_val("wrap_rd_en_after", {31'd0, rd_en}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
